// File: rtl/regfile_apb_arbiter.sv
// Round-robin arbiter that shares one APB slave port among NUM_REQ requesters.
// Each grant runs SETUP/ACCESS; ACCESS is bounded by TIMEOUT cycles without pready.
module regfile_apb_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d, grant_q, grant_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                found;
  logic [IdxW-1:0]     pick, cand;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;
  logic                timed_out;

  // A requester being acked this cycle drops req on the same edge, so mask it.
  assign eligible  = req & ~ack_q;
  assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    found     = 1'b0;
    pick      = '0;
    cand      = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick == IdxW'(k)) begin
        sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[k*DATA_W +: DATA_W];
        sel_write = req_write[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (found) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready || timed_out) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ack_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d   = pick;
          ptr_d     = (pick == IdxW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          paddr_d   = sel_addr;
          pwdata_d  = sel_wdata;
          pwrite_d  = sel_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      StSetup: penable_d = 1'b1;
      StAccess: begin
        if (pready || timed_out) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          cnt_d     = '0;
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            ack_d[k] = (grant_q == IdxW'(k));
          end
          // pready wins over a simultaneous timeout.
          if (pready) begin
            err_d   = pslverr;
            rdata_d = pwrite_q ? '0 : prdata;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ack_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
    end
  end

  assign req_ack   = ack_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_regfile_apb_arbiter.sv
// Bench for regfile_apb_arbiter: directed scenarios with literal expectations, then random
// requesters and slave checked every cycle against a transaction-level reference model.
module tb_regfile_apb_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, req_write, req_ack;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic            rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;

  int n_chk  = 0;
  int n_fail = 0;
  bit rand_en = 1'b0;
  bit chk_on  = 1'b0;
  int ws_cfg  = 0;
  bit err_cfg = 1'b0;
  logic [DW-1:0] rd_cfg = '0;
  int acc_cyc = 0;

  regfile_apb_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks one transfer as "cycles since grant" and applies the arbitration,
  // completion and timeout rules at each clock edge.
  bit            m_busy;
  int            m_since, m_gnt, m_ptr;
  logic [N-1:0]  m_ack;
  logic [DW-1:0] m_rdata, m_pwdata;
  logic [AW-1:0] m_paddr;
  bit            m_err, m_pwrite;

  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0] seen;
    bit hit;
    int w;
    if (!rst_n) begin
      m_busy = 1'b0; m_since = 0; m_gnt = 0; m_ptr = 0; m_ack = '0;
      m_rdata = '0; m_err = 1'b0; m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
    end else begin
      seen  = m_ack;
      m_ack = '0;
      if (!m_busy) begin
        hit = 1'b0;
        w   = 0;
        for (int k = 0; k < N; k++) begin
          if (!hit && req[(m_ptr + k) % N] && !seen[(m_ptr + k) % N]) begin
            hit = 1'b1;
            w   = (m_ptr + k) % N;
          end
        end
        if (hit) begin
          m_busy = 1'b1; m_since = 0; m_gnt = w; m_ptr = (w + 1) % N;
          m_paddr  = req_addr[w*AW +: AW];
          m_pwdata = req_wdata[w*DW +: DW];
          m_pwrite = req_write[w];
        end
      end else if (m_since == 0) begin
        m_since = 1;
      end else if (pready || m_since == TO) begin
        m_busy       = 1'b0;
        m_ack[m_gnt] = 1'b1;
        m_err        = pready ? pslverr : 1'b1;
        m_rdata      = (pready && !m_pwrite) ? prdata : '0;
        m_since      = 0;
      end else begin
        m_since++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("psel", psel, m_busy);
      chk("penable", penable, m_busy && m_since > 0);
      chk("req_ack", req_ack, m_ack);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
      chk("paddr", paddr, m_paddr);
      chk("pwrite", pwrite, m_pwrite);
      chk("pwdata", pwdata, m_pwdata);
    end
  end

  // APB slave: pready after ws_cfg wait states in ACCESS; noise elsewhere in random mode.
  always @(negedge clk) begin
    if (psel && penable) begin
      pready = (acc_cyc >= ws_cfg);
      acc_cyc++;
    end else begin
      acc_cyc = 0;
      pready  = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (pready || !rand_en) begin
      prdata  = rd_cfg;
      pslverr = pready ? err_cfg : 1'b0;
    end else begin
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic xfer(input int i, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int ws, input bit se,
                      input logic [DW-1:0] rdv, output int lat, output int pen,
                      output int psat, output logic [DW-1:0] pw, output logic [DW-1:0] rd,
                      output bit er);
    ws_cfg = ws; err_cfg = se; rd_cfg = rdv;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
    lat = 0; pen = 0; psat = 0; pw = '0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (psel && psat == 0) psat = c;
      // Post-grant changes must not reach the bus.
      if (psel) begin
        req_addr[i*AW +: AW]  = ~a;
        req_wdata[i*DW +: DW] = ~d;
      end
      if (penable) begin
        pen++;
        pw = pwdata;
      end
      if (req_ack[i]) begin
        lat = c; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    req[i] = 1'b0;
  endtask

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        idx = req_ack[1] ? 1 : 0;
        req[idx] = 1'b0;
        break;
      end
    end
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < N; i++) begin
      if (req[i] && req_ack[i]) begin
        req[i] = 1'b0;
      end else if (!req[i]) begin
        if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_write[i] = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW] = 8'($urandom);
          req_wdata[i*DW +: DW] = $urandom;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req_write[i] = 1'($urandom_range(0, 1));
        req_addr[i*AW +: AW] = 8'($urandom);
        req_wdata[i*DW +: DW] = $urandom;
      end else if ($urandom_range(0, 63) == 0) begin
        req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, pen, psat, idx, got, first_psel, lowc, first_ack, last_ack;
    int order [8];
    logic [DW-1:0] pw, rd;
    bit er;

    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_paddr", paddr, 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Zero-wait write from requester 0
    xfer(0, 1'b1, 8'h0C, 32'hCAFEF00D, 0, 1'b0, 32'h0, lat, pen, psat, pw, rd, er);
    chk("t1_psel_cycle", psat, 1);
    chk("t1_ack_cycle", lat, 3);
    chk("t1_penable_cycles", pen, 1);
    chk("t1_pwdata", pw, 32'hCAFEF00D);
    chk("t1_err", er, 0);

    // Read with two wait states from requester 1
    xfer(1, 1'b0, 8'h00, 32'h0, 2, 1'b0, 32'h3, lat, pen, psat, pw, rd, er);
    chk("t2_ack_cycle", lat, 5);
    chk("t2_penable_cycles", pen, 3);
    chk("t2_rdata", rd, 32'h3);
    chk("t2_err", er, 0);

    // Both requesters held: alternating grants, one idle bus cycle between transfers
    do_reset();
    ws_cfg = 0; err_cfg = 1'b0; rd_cfg = '0;
    req_write = 2'b01;
    req_addr  = {8'h14, 8'h10};
    req_wdata = {32'h1111_1111, 32'h2222_2222};
    for (int k = 0; k < 8; k++) order[k] = -1;
    got = 0; first_psel = 0; lowc = 0; first_ack = 0; last_ack = 0;
    req = 2'b11;
    for (int c = 1; c <= 200 && got < 8; c++) begin
      @(negedge clk);
      if (psel && first_psel == 0) first_psel = c;
      if (first_psel != 0 && !psel) lowc++;
      if (req_ack != '0) begin
        order[got] = req_ack[1] ? 1 : 0;
        if (got == 0) first_ack = c;
        got++;
        last_ack = c;
      end
    end
    req = '0;
    chk("t3_count", got, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("t3_grant%0d", k), order[k], k % 2);
    chk("t3_idle_cycles", lowc, 8);
    chk("t3_span", last_ack - first_ack, 21);
    repeat (4) @(negedge clk);

    // Timeout on a read, then a normal read
    do_reset();
    xfer(0, 1'b0, 8'h20, 32'h0, 100, 1'b0, 32'hDEADBEEF, lat, pen, psat, pw, rd, er);
    chk("t4_penable_cycles", pen, 16);
    chk("t4_ack_cycle", lat, 18);
    chk("t4_err", er, 1);
    chk("t4_rdata", rd, 0);
    xfer(1, 1'b0, 8'h24, 32'h0, 1, 1'b0, 32'h12345678, lat, pen, psat, pw, rd, er);
    chk("t4_next_err", er, 0);
    chk("t4_next_rdata", rd, 32'h12345678);

    // Slave error on a write affects only that ack
    do_reset();
    xfer(0, 1'b1, 8'h04, 32'h55AA55AA, 0, 1'b1, 32'hFFFFFFFF, lat, pen, psat, pw, rd, er);
    chk("t5_err", er, 1);
    chk("t5_rdata", rd, 0);
    xfer(1, 1'b1, 8'h08, 32'h1, 0, 1'b0, 32'hFFFFFFFF, lat, pen, psat, pw, rd, er);
    chk("t5_next_err", er, 0);

    // Asynchronous reset during ACCESS
    do_reset();
    ws_cfg = 100;
    req_write[1] = 1'b0;
    req_addr[AW +: AW] = 8'h10;
    req[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_in_access", penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_psel", psel, 0);
    chk("t6_rst_penable", penable, 0);
    chk("t6_rst_ack", req_ack, 0);
    @(negedge clk);
    ws_cfg = 0;
    req_write[0] = 1'b1;
    req_addr[0 +: AW] = 8'h30;
    req = 2'b11;
    rst_n = 1'b1;
    wait_ack(idx);
    chk("t6_first_grant", idx, 0);
    wait_ack(idx);
    chk("t6_second_grant", idx, 1);

    // Random traffic against the model
    do_reset();
    rand_en = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      rand_reqs();
      if (psel && !penable) begin
        ws_cfg  = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 3));
        err_cfg = ($urandom_range(0, 3) == 0);
        rd_cfg  = $urandom;
      end
    end
    rand_en = 1'b0;
    req = '0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
